// File: rtl/tl_channel_buffer_coupler.sv
// tl_channel_buffer_coupler
//   TileLink-UL A/D channel coupler. It holds an independent FIFO on the A (request) channel and
//   another on the D (response) channel. It sits between a crossbar port and a downstream slave or
//   adapter, where it breaks timing paths and absorbs bursts. Beat contents are never altered and
//   each channel keeps strict beat order.
//
// Configuration macro:
//   TL_BUF_FLOW_EN - when defined, an empty FIFO forwards its input beat to its output in the same
//                    cycle. A beat that is dequeued in that cycle is not stored. When undefined,
//                    no input valid or bits signal reaches any output combinationally.
//
// Ports:
//   clock                         single clock; all state changes on the rising edge
//   reset                         synchronous, active-low
//   in_a_valid/in_a_ready/in_a_bits     upstream A channel (sink side of the A FIFO)
//   out_a_valid/out_a_ready/out_a_bits  downstream A channel (source side of the A FIFO)
//   out_d_valid/out_d_ready/out_d_bits  downstream D channel (sink side of the D FIFO)
//   in_d_valid/in_d_ready/in_d_bits     upstream D channel (source side of the D FIFO)
//   a_count, d_count              FIFO occupancy; tied to 0 when the depth is 0
//
// A beat packing, MSB first: {opcode[3], param[3], size, source, address, mask, data, corrupt}
// D beat packing, MSB first: {opcode[3], param[2], size, source, sink, denied, data, corrupt}

module tl_channel_buffer_coupler #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned SOURCE_W = 1,
    parameter int unsigned SINK_W   = 2,
    parameter int unsigned SIZE_W   = 4,
    parameter int unsigned A_DEPTH  = 2,
    parameter int unsigned D_DEPTH  = 2,
    localparam int unsigned A_W = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
    localparam int unsigned D_W = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1
) (
    input  logic           clock,
    input  logic           reset,

    input  logic           in_a_valid,
    output logic           in_a_ready,
    input  logic [A_W-1:0] in_a_bits,

    output logic           out_a_valid,
    input  logic           out_a_ready,
    output logic [A_W-1:0] out_a_bits,

    input  logic           out_d_valid,
    output logic           out_d_ready,
    input  logic [D_W-1:0] out_d_bits,

    output logic           in_d_valid,
    input  logic           in_d_ready,
    output logic [D_W-1:0] in_d_bits,

    output logic [4:0]     a_count,
    output logic [4:0]     d_count
);

    // ------------------------------------------------------------------------------------------
    // A channel: in_a -> out_a
    // ------------------------------------------------------------------------------------------
    if (A_DEPTH == 0) begin : g_a_pass
        assign out_a_valid = in_a_valid;
        assign in_a_ready  = out_a_ready;
        assign out_a_bits  = in_a_bits;
        assign a_count     = 5'd0;
    end else begin : g_a_fifo
        localparam int unsigned PTR_W = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(A_DEPTH - 1);
        localparam logic [4:0] FULL_CNT = 5'(A_DEPTH);

        logic [A_W-1:0]   mem_q [A_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [4:0]       count_q, count_d;
        logic             enq, deq;
        logic             empty;

        assign empty      = (count_q == 5'd0);
        // Ready looks only at occupancy, so a full FIFO never accepts on a draining cycle.
        assign in_a_ready = (count_q != FULL_CNT);
        assign a_count    = count_q;

`ifdef TL_BUF_FLOW_EN
        logic flow;
        // Bypass is suppressed while reset is asserted so no beat appears during reset.
        assign flow        = reset & empty & in_a_valid;
        assign out_a_valid = ~empty | flow;
        assign out_a_bits  = empty ? in_a_bits : mem_q[rd_ptr_q];
        // A bypassed beat that is taken downstream in the same cycle is never stored.
        assign enq         = in_a_valid & in_a_ready & ~(flow & out_a_ready);
        assign deq         = ~empty & out_a_ready;
`else
        assign out_a_valid = ~empty;
        assign out_a_bits  = mem_q[rd_ptr_q];
        assign enq         = in_a_valid & in_a_ready;
        assign deq         = ~empty & out_a_ready;
`endif

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (enq) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= 5'd0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is deliberately left out of reset; occupancy alone qualifies its contents.
        always_ff @(posedge clock) begin
            if (enq) begin
                mem_q[wr_ptr_q] <= in_a_bits;
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // D channel: out_d -> in_d
    // ------------------------------------------------------------------------------------------
    if (D_DEPTH == 0) begin : g_d_pass
        assign in_d_valid  = out_d_valid;
        assign out_d_ready = in_d_ready;
        assign in_d_bits   = out_d_bits;
        assign d_count     = 5'd0;
    end else begin : g_d_fifo
        localparam int unsigned PTR_W = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(D_DEPTH - 1);
        localparam logic [4:0] FULL_CNT = 5'(D_DEPTH);

        logic [D_W-1:0]   mem_q [D_DEPTH];
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [4:0]       count_q, count_d;
        logic             enq, deq;
        logic             empty;

        assign empty       = (count_q == 5'd0);
        assign out_d_ready = (count_q != FULL_CNT);
        assign d_count     = count_q;

`ifdef TL_BUF_FLOW_EN
        logic flow;
        assign flow       = reset & empty & out_d_valid;
        assign in_d_valid = ~empty | flow;
        assign in_d_bits  = empty ? out_d_bits : mem_q[rd_ptr_q];
        assign enq        = out_d_valid & out_d_ready & ~(flow & in_d_ready);
        assign deq        = ~empty & in_d_ready;
`else
        assign in_d_valid = ~empty;
        assign in_d_bits  = mem_q[rd_ptr_q];
        assign enq        = out_d_valid & out_d_ready;
        assign deq        = ~empty & in_d_ready;
`endif

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (enq) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= 5'd0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        always_ff @(posedge clock) begin
            if (enq) begin
                mem_q[wr_ptr_q] <= out_d_bits;
            end
        end
    end

endmodule

// File: tb/tb_tl_channel_buffer_coupler.sv
// Self-checking bench for tl_channel_buffer_coupler (A_DEPTH=2, D_DEPTH=3).
module tb_tl_channel_buffer_coupler;

    localparam int A_W = 116;
    localparam int D_W = 78;
`ifdef TL_BUF_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic           in_a_valid, in_a_ready, out_a_valid, out_a_ready;
    logic [A_W-1:0] in_a_bits, out_a_bits;
    logic           out_d_valid, out_d_ready, in_d_valid, in_d_ready;
    logic [D_W-1:0] out_d_bits, in_d_bits;
    logic [4:0]     a_count, d_count;

    int tests = 0;
    int fails = 0;

    logic [A_W-1:0] qa[$];
    logic [D_W-1:0] qd[$];

    tl_channel_buffer_coupler #(
        .A_DEPTH(2),
        .D_DEPTH(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_a_valid (in_a_valid),
        .in_a_ready (in_a_ready),
        .in_a_bits  (in_a_bits),
        .out_a_valid(out_a_valid),
        .out_a_ready(out_a_ready),
        .out_a_bits (out_a_bits),
        .out_d_valid(out_d_valid),
        .out_d_ready(out_d_ready),
        .out_d_bits (out_d_bits),
        .in_d_valid (in_d_valid),
        .in_d_ready (in_d_ready),
        .in_d_bits  (in_d_bits),
        .a_count    (a_count),
        .d_count    (d_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [A_W-1:0] mk_a(input logic [31:0] addr, input logic [63:0] data);
        return {3'd4, 3'd0, 4'd3, 1'b0, addr, 8'hff, data, 1'b0};
    endfunction

    function automatic logic [D_W-1:0] mk_d(input logic [63:0] data);
        return {3'd1, 2'd0, 4'd3, 1'b0, 2'd1, 1'b0, data, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each row: inputs held across one rising edge, outputs checked 1 time unit after it.
    typedef struct {
        logic        rst;
        logic        av;
        logic [31:0] addr;
        logic        ordy;
        logic        e_irdy;
        logic        e_oval;
        logic [4:0]  e_cnt;
        logic [31:0] e_oaddr;
    } vec_t;

    vec_t vecs[13];

    // Randomised traffic on both channels, checked against queue models of the two FIFOs.
    task automatic run_stream(input int n_a, input int n_d, input bit seq_d);
        int sent_a = 0, recv_a = 0, sent_d = 0, recv_d = 0, cyc = 0;
        int budget = 40 * (n_a + n_d) + 200;
        bit acc_a, acc_d;
        qa.delete();
        qd.delete();
        in_a_valid = 1'b0;
        out_d_valid = 1'b0;
        while ((recv_a < n_a || recv_d < n_d) && cyc < budget) begin
            // Upstream sources hold a beat stable until it is accepted.
            if (!in_a_valid && sent_a < n_a && $urandom_range(3) != 0) begin
                in_a_valid = 1'b1;
                in_a_bits  = mk_a($urandom, {$urandom, $urandom});
            end
            if (!out_d_valid && sent_d < n_d && $urandom_range(3) != 0) begin
                out_d_valid = 1'b1;
                out_d_bits  = mk_d(seq_d ? 64'(sent_d) : {$urandom, $urandom});
            end
            out_a_ready = 1'($urandom_range(1));
            in_d_ready  = 1'($urandom_range(1));
            #1;
            chk("a_ready_rule", in_a_ready, qa.size() != 2);
            chk("a_count_model", a_count, 5'(qa.size()));
            chk("a_valid_rule", out_a_valid, (qa.size() != 0) || (FLOW && in_a_valid));
            chk("d_ready_rule", out_d_ready, qd.size() != 3);
            chk("d_count_model", d_count, 5'(qd.size()));
            chk("d_count_max", d_count <= 5'd3, 1'b1);
            chk("d_valid_rule", in_d_valid, (qd.size() != 0) || (FLOW && out_d_valid));
            acc_a = in_a_valid && in_a_ready;
            acc_d = out_d_valid && out_d_ready;
            if (acc_a) begin
                qa.push_back(in_a_bits);
                sent_a++;
            end
            if (acc_d) begin
                qd.push_back(out_d_bits);
                sent_d++;
            end
            if (out_a_valid && out_a_ready) begin
                if (qa.size() == 0) chk("a_spurious_beat", 1'b1, 1'b0);
                else chk("a_order", out_a_bits, qa.pop_front());
                recv_a++;
            end
            if (in_d_valid && in_d_ready) begin
                if (qd.size() == 0) chk("d_spurious_beat", 1'b1, 1'b0);
                else chk("d_order", in_d_bits, qd.pop_front());
                recv_d++;
            end
            @(posedge clock);
            #1;
            if (acc_a) in_a_valid = 1'b0;
            if (acc_d) out_d_valid = 1'b0;
            cyc++;
        end
        in_a_valid  = 1'b0;
        out_d_valid = 1'b0;
        out_a_ready = 1'b0;
        in_d_ready  = 1'b0;
        chk("a_beats_received", 32'(recv_a), 32'(n_a));
        chk("d_beats_received", 32'(recv_d), 32'(n_d));
        #1;
        chk("a_count_drained", a_count, 5'd0);
        chk("d_count_drained", d_count, 5'd0);
    endtask

    initial begin
        reset       = 1'b0;
        in_a_valid  = 1'b0;
        in_a_bits   = '0;
        out_a_ready = 1'b0;
        out_d_valid = 1'b0;
        out_d_bits  = '0;
        in_d_ready  = 1'b0;

        //          rst   av    addr      ordy  irdy  oval  cnt   oaddr
        vecs[0]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};     // reset held
        vecs[1]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1000};  // fill
        vecs[4]  = '{1'b1, 1'b1, 32'h1040, 1'b0, 1'b0, 1'b1, 5'd2, 32'h1000};
        vecs[5]  = '{1'b1, 1'b1, 32'h1080, 1'b0, 1'b0, 1'b1, 5'd2, 32'h1000};  // full, held off
        vecs[6]  = '{1'b1, 1'b1, 32'h1080, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1040};  // full: deq only
        vecs[7]  = '{1'b1, 1'b1, 32'h1080, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1080};  // enq+deq
        vecs[8]  = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd0, 32'h0};     // drain
        vecs[9]  = '{1'b1, 1'b1, 32'h1100, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1100};
        vecs[10] = '{1'b1, 1'b1, 32'h1140, 1'b0, 1'b0, 1'b1, 5'd2, 32'h1100};
        vecs[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd0, 32'h0};     // reset mid-op
        vecs[12] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd0, 32'h0};     // nothing emitted

        for (int i = 0; i < 13; i++) begin
            reset       = vecs[i].rst;
            in_a_valid  = vecs[i].av;
            in_a_bits   = mk_a(vecs[i].addr, 64'h0);
            out_a_ready = vecs[i].ordy;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_in_a_ready", i), in_a_ready, vecs[i].e_irdy);
            chk($sformatf("vec%0d_out_a_valid", i), out_a_valid, vecs[i].e_oval);
            chk($sformatf("vec%0d_a_count", i), a_count, vecs[i].e_cnt);
            if (vecs[i].e_oval) begin
                chk($sformatf("vec%0d_out_a_bits", i), out_a_bits, mk_a(vecs[i].e_oaddr, 64'h0));
            end
            chk($sformatf("vec%0d_in_d_valid", i), in_d_valid, 1'b0);
        end
        in_a_valid  = 1'b0;
        out_a_ready = 1'b0;

        // D channel wrap: ten sequential beats through a three-entry FIFO.
        run_stream(0, 10, 1'b1);
        // Mixed random traffic on both channels.
        run_stream(150, 150, 1'b0);

        // Empty FIFO with a ready sink: same-cycle forward only with the bypass build.
        in_a_valid  = 1'b1;
        in_a_bits   = mk_a(32'h2000, 64'h0);
        out_a_ready = 1'b1;
        #1;
        chk("empty_push_valid_same_cycle", out_a_valid, FLOW);
        chk("empty_push_count_same_cycle", a_count, 5'd0);
        @(posedge clock);
        #1;
        in_a_valid = 1'b0;
        #1;
        chk("empty_push_valid_next_cycle", out_a_valid, !FLOW);
        chk("empty_push_count_next_cycle", a_count, FLOW ? 5'd0 : 5'd1);
        chk("empty_push_bits_next_cycle", out_a_bits, mk_a(32'h2000, 64'h0));
        @(posedge clock);
        #1;
        chk("empty_push_drained", a_count, 5'd0);
        chk("empty_push_valid_drained", out_a_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
